tdm_demux_1to4: RTL and testbench
=================================

// Module: tdm_demux_1to4
// PURPOSE
//  Receive end of the 4:1 mux link. Accepts the time-multiplexed stream produced by a
//  4:1 mux whose select sweeps 0..3, and rebuilds the four parallel lanes.
//  Emits one registered 4-lane word per frame over a valid/ready output handshake.
//  Sits between the serial mux link and any parallel consumer.
// PARAMETERS
//  WIDTH      1    bits per lane / per serial beat
// PORTS
//  clk         in   1          single clock; all logic on posedge
//  rst_n       in   1          asynchronous active-low reset
//  din         in   WIDTH      serial beat (mux output Y)
//  din_valid   in   1          din carries a beat this cycle; no input backpressure
//  sync_in     in   1          qualified by din_valid: this beat is lane 0 (Sel=00)
//  lane_sel    out  2          lane index the next valid beat will be written to
//  out_data    out  4*WIDTH    {lane3,lane2,lane1,lane0}; lane0 in bits [WIDTH-1:0]
//  out_valid   out  1          out_data holds a complete frame
//  out_ready   in   1          consumer accepts out_data when out_valid && out_ready
//  overrun     out  1          1-cycle pulse: completed frame dropped, output still full
//  frame_err   out  1          1-cycle pulse: early sync (FRAME_ERR_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (async assert, sync release): state HUNT, lane_sel=0, lane regs=0, out_data=0,
//    out_valid=0, overrun=0, frame_err=0. Reset mid-frame discards the partial frame.
//  - States: HUNT (no frame alignment), COLLECT (aligned).
//    HUNT: valid beats without sync_in are discarded. A valid beat with sync_in is written
//    to lane 0, lane_sel becomes 1, state becomes COLLECT.
//    COLLECT: each valid beat writes lane[lane_sel]; lane_sel increments mod 4.
//  - din_valid=0: no state, lane or lane_sel change; sync_in is ignored.
//  - Sync in COLLECT with lane_sel==0: normal frame start.
//  - Sync in COLLECT with lane_sel!=0: the partial frame is discarded. The beat is written
//    to lane 0 and lane_sel becomes 1.
//  - Lane-3 beat (frame complete): the output reg loads if out_valid==0 or
//    (out_valid && out_ready) in the same cycle. out_valid=1 on the next cycle.
//    Latency is 1 clk from the lane-3 beat to out_valid.
//    Otherwise the frame is dropped, out_data is unchanged, and overrun pulses next cycle.
//    lane_sel wraps to 0 in both cases.
//  - Output hold: out_data and out_valid are stable while out_valid && !out_ready.
//    Acceptance without a new frame clears out_valid next cycle.
//  - The output reg is separate from the lane regs, so back-to-back frames (1 beat/clk)
//    sustain full throughput when out_ready=1.
// CONFIGURATION
//  TDM_DEMUX_FRAME_ERR_EN defined: an early sync in COLLECT (lane_sel!=0) pulses
//    frame_err for 1 cycle (registered).
//  Not defined: frame_err is a constant 0; early-sync resync behaviour is identical.
// STRUCTURE
//  tdm_demux_pkg: LANES=4, SEL_W=2, typedef enum logic {HUNT, COLLECT} state_t.
//  Sub-module tdm_demux_lane_cnt: 2-bit lane counter with inc/clear-on-sync and a
//    last-lane flag; drives lane_sel. Top holds the lane regs, output reg, handshake
//    and pulses.
// TESTING (WIDTH=1, out_ready=1 unless stated)
//  1 Beats 0,1,1,0 with sync on beat 1 -> out_data=4'b0110, out_valid 1 cycle after beat 4.
//  2 Beats 0,1,0,1 then 1,0,1,0 back-to-back, sync each beat 1 -> 4'b1010 then 4'b0101
//    on consecutive frames; no overrun.
//  3 Three valid beats before any sync -> no out_valid, lane_sel stays 0 (HUNT).
//  4 out_ready=0, two full frames -> first frame held, overrun pulse after the 2nd frame's
//    lane-3 beat; out_ready=1 -> first frame accepted, out_valid drops.
//  5 Sync on the 3rd beat of a frame -> partial frame discarded, next frame aligned.
//    frame_err=1 for 1 cycle only with TDM_DEMUX_FRAME_ERR_EN.
//  6 rst_n low after 2 beats -> all outputs 0 immediately; after release, HUNT until sync.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux_pkg
//  Description : Shared constants and types for the 1:4 TDM demultiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdm_demux_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    // Index of the lane whose beat completes a frame
    localparam logic [SEL_W-1:0] c_last_lane = SEL_W'(LANES - 1);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage : tdm_demux_pkg
`default_nettype wire

// File: rtl/tdm_demux_lane_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux_lane_cnt
//  Description : Lane pointer for the TDM demux. A sync beat always lands in
//                lane 0, so sync forces the pointer to 1; an ordinary aligned
//                beat advances it modulo 4. Flags the last lane of a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_lane_cnt
    import tdm_demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             sync,
    output logic [SEL_W-1:0] lane_sel,
    output logic             last
);

    logic [SEL_W-1:0] r_sel;

    // Lane pointer: sync wins over increment so an early sync realigns at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
        end else if (sync) begin
            r_sel <= SEL_W'(1);
        end else if (inc) begin
            r_sel <= r_sel + SEL_W'(1);
        end
    end

    assign lane_sel = r_sel;
    assign last     = (r_sel == c_last_lane);

endmodule : tdm_demux_lane_cnt
`default_nettype wire

// File: rtl/tdm_demux_1to4.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux_1to4
//  Description : Receive end of a 4:1 TDM link. Rebuilds four parallel lanes
//                from the serial beat stream and presents one registered
//                frame per valid/ready handshake. Frames that complete while
//                the output is still full are dropped and flagged (overrun).
//  Config      : TDM_DEMUX_FRAME_ERR_EN - when defined, an early sync while
//                aligned pulses frame_err; otherwise frame_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_1to4
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    input  logic                   sync_in,
    output logic [SEL_W-1:0]       lane_sel,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overrun,
    output logic                   frame_err
);

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [SEL_W-1:0]             w_lane_sel;
    logic                         w_last;
    logic                         w_sync_beat;
    logic                         w_inc;
    logic                         w_beat_wr;
    logic [SEL_W-1:0]             w_wr_sel;
    logic                         w_complete;
    logic                         w_load;
    logic [(LANES-1)*WIDTH-1:0]   w_lanes;
    logic [LANES*WIDTH-1:0]       r_out_data;
    logic                         r_out_valid;
    logic                         r_overrun;

    // A sync beat is lane 0 regardless of state; other beats only count once aligned
    assign w_sync_beat = din_valid && sync_in;
    assign w_inc       = din_valid && !sync_in && (r_state == COLLECT);
    assign w_beat_wr   = w_sync_beat || w_inc;
    assign w_wr_sel    = sync_in ? '0 : w_lane_sel;

    // Lane-3 beat completes the frame; it bypasses the lane regs straight into the output
    assign w_complete  = w_inc && w_last;
    assign w_load      = w_complete && (!r_out_valid || out_ready);

    tdm_demux_lane_cnt u_lane_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (w_inc),
        .sync     (w_sync_beat),
        .lane_sel (w_lane_sel),
        .last     (w_last)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: any sync beat aligns us; alignment is only lost through reset
    always_comb begin
        w_state_nxt = r_state;
        if (w_sync_beat) begin
            w_state_nxt = COLLECT;
        end
    end

    // Lane holding registers for lanes 0..2
    generate
        for (genvar k = 0; k < LANES - 1; k++) begin : g_lane
            logic [WIDTH-1:0] r_lane;

            // Capture the beat addressed to this lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_lane <= '0;
                end else if (w_beat_wr && (w_wr_sel == SEL_W'(k))) begin
                    r_lane <= din;
                end
            end

            assign w_lanes[k*WIDTH +: WIDTH] = r_lane;
        end
    endgenerate

    // Output register and handshake: load a completed frame if the slot is free or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= {din, w_lanes};
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Overrun pulse: a frame completed but the output slot was still occupied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_complete && !w_load;
        end
    end

`ifdef TDM_DEMUX_FRAME_ERR_EN
    logic r_frame_err;

    // Frame error pulse: sync arrived while aligned but mid-frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_sync_beat && (r_state == COLLECT) && (w_lane_sel != '0);
        end
    end

    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

    assign lane_sel  = w_lane_sel;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;

endmodule : tdm_demux_1to4
`default_nettype wire

// File: tb/tb_tdm_demux_1to4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux_1to4
//  Description : Self-checking bench for tdm_demux_1to4 (WIDTH=1). Expected
//                frames are queued as stimulus is driven and compared when
//                the DUT hands a frame over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_1to4;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       din_valid;
    logic       sync_in;
    logic [1:0] lane_sel;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;
    logic       frame_err;

    int         n_checks;
    int         n_fails;
    int         n_ovr;
    int         n_ferr;
    logic [3:0] sb [$];

    tdm_demux_1to4 #(.WIDTH(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .sync_in   (sync_in),
        .lane_sel  (lane_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One cycle of input, starting and ending 1 time unit after a rising edge
    task automatic beat(input logic d, input logic s);
        din       = d;
        sync_in   = s;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din       = 1'b0;
        sync_in   = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // f[i] is the beat for lane i; sync on lane 0
    task automatic send_frame(input logic [3:0] f, input bit expect_out);
        if (expect_out) sb.push_back(f);
        beat(f[0], 1'b1);
        for (int i = 1; i < 4; i++) beat(f[i], 1'b0);
    endtask

    // Scoreboard and pulse counters, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_unexpected_frame", {28'd0, out_data}, 32'hFFFF_FFFF);
                else                chk("sb_frame", {28'd0, out_data}, {28'd0, sb.pop_front()});
            end
            if (overrun)   n_ovr++;
            if (frame_err) n_ferr++;
        end
    end

    initial begin
        int ovr0;
        int exp_ferr;
        n_checks  = 0;
        n_fails   = 0;
        n_ovr     = 0;
        n_ferr    = 0;
        rst_n     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        sync_in   = 1'b0;
        out_ready = 1'b1;
`ifdef TDM_DEMUX_FRAME_ERR_EN
        exp_ferr = 1;
`else
        exp_ferr = 0;
`endif

        // Reset state
        idle(2);
        chk("rst_lane_sel", {30'd0, lane_sel}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", {28'd0, out_data}, 0);
        chk("rst_overrun", {31'd0, overrun}, 0);
        chk("rst_frame_err", {31'd0, frame_err}, 0);
        rst_n = 1'b1;
        idle(1);

        // Unsynced beats are discarded while hunting
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 1'b0);
            chk("hunt_lane_sel", {30'd0, lane_sel}, 0);
            chk("hunt_out_valid", {31'd0, out_valid}, 0);
        end

        // Basic frame and 1-cycle latency
        send_frame(4'b0110, 1'b1);
        chk("t1_valid_latency", {31'd0, out_valid}, 1);
        chk("t1_data", {28'd0, out_data}, 32'h6);
        chk("t1_lane_sel_wrap", {30'd0, lane_sel}, 0);
        idle(1);
        chk("t1_valid_drop", {31'd0, out_valid}, 0);

        // Back-to-back frames at full rate
        ovr0 = n_ovr;
        send_frame(4'b1010, 1'b1);
        chk("t2_f1_data", {28'd0, out_data}, 32'hA);
        send_frame(4'b0101, 1'b1);
        chk("t2_f2_valid", {31'd0, out_valid}, 1);
        chk("t2_f2_data", {28'd0, out_data}, 32'h5);
        idle(1);
        chk("t2_no_overrun", n_ovr - ovr0, 0);

        // Stalled output: second frame dropped with an overrun pulse
        out_ready = 1'b0;
        ovr0 = n_ovr;
        send_frame(4'b0011, 1'b1);
        send_frame(4'b1100, 1'b0);
        chk("t4_overrun_pulse", {31'd0, overrun}, 1);
        chk("t4_held_valid", {31'd0, out_valid}, 1);
        chk("t4_held_data", {28'd0, out_data}, 32'h3);
        idle(1);
        chk("t4_overrun_1cyc", {31'd0, overrun}, 0);
        chk("t4_overrun_count", n_ovr - ovr0, 1);
        chk("t4_still_held", {28'd0, out_data}, 32'h3);
        out_ready = 1'b1;
        idle(1);
        chk("t4_accept_drop", {31'd0, out_valid}, 0);

        // Early sync on the third beat realigns
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b0);
        sb.push_back(4'b1010);
        beat(1'b0, 1'b1);
        chk("t5_resync_lane_sel", {30'd0, lane_sel}, 1);
        chk("t5_frame_err", {31'd0, frame_err}, exp_ferr);
        beat(1'b1, 1'b0);
        chk("t5_frame_err_1cyc", {31'd0, frame_err}, 0);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        chk("t5_data", {28'd0, out_data}, 32'hA);
        idle(1);
        chk("t5_ferr_count", n_ferr, exp_ferr);

        // Reset mid-frame
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_lane_sel", {30'd0, lane_sel}, 0);
        chk("t6_rst_out_data", {28'd0, out_data}, 0);
        chk("t6_rst_out_valid", {31'd0, out_valid}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) beat(1'b1, 1'b0);
        chk("t6_hunt_lane_sel", {30'd0, lane_sel}, 0);
        chk("t6_hunt_valid", {31'd0, out_valid}, 0);
        send_frame(4'b1001, 1'b1);
        chk("t6_data", {28'd0, out_data}, 32'h9);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            idle(1);
        end
        idle(1);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_tdm_demux_1to4
`default_nettype wire
